capture_seq: RTL and testbench

Capture sequencer for the logic-analyzer front end. It owns the `armed` signal that feeds every channel trigger block and combines their per-channel `CH_Trig` outputs into one trigger. It also sequences sample writes into the circular capture RAM: pre-trigger fill, armed wait, trigger detection, post-trigger count, done. It sits between the command/host interface (start, ack, post-trigger count) and the channel trigger / capture RAM datapath.

---
 rtl/capture_seq.sv | 159 +++++++++++++++
 tb/tb_capture_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_seq.sv
// Capture sequencer: owns the channel-trigger arm signal, combines channel triggers,
// and steps capture RAM writes through prefill, armed wait, post-trigger count and done.
module capture_seq #(
  parameter int ADDR_W = 9,
  parameter int NUM_CH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr_done,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] CH_Trig,
  output logic              armed,
  output logic              triggered,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic              pend_q, pend_d;
  logic              triggered_q, triggered_d;
  logic              armed_q;
  logic              done_q;
  logic              we_c;
  logic              all_trig;
  logic [ADDR_W-1:0] pre_target;

  assign all_trig   = &CH_Trig;
  assign pre_target = {ADDR_W{1'b1}} - tp_q;

  // pend_q marks a trigger taken without a strobe: the next strobed sample is the
  // trigger sample itself, lands at trig_addr and does not consume the post count.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    tp_d        = tp_q;
    pend_d      = pend_q;
    triggered_d = triggered_q;
    we_c        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PREFILL;
          waddr_d     = '0;
          pre_cnt_d   = '0;
          tp_d        = trig_pos;
          triggered_d = 1'b0;
          pend_d      = 1'b0;
        end
      end
      S_PREFILL: begin
        if (sample_en) begin
          we_c      = 1'b1;
          waddr_d   = waddr_q + ADDR_W'(1);
          pre_cnt_d = pre_cnt_q + ADDR_W'(1);
        end
        if (pre_cnt_q >= pre_target) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_en) begin
          we_c    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
        end
        if (all_trig) begin
          state_d     = S_POST;
          trig_addr_d = waddr_q;
          triggered_d = 1'b1;
          post_cnt_d  = tp_q;
          pend_d      = ~sample_en;
        end
      end
      S_POST: begin
        if (pend_q) begin
          if (sample_en) begin
            we_c    = 1'b1;
            waddr_d = waddr_q + ADDR_W'(1);
            pend_d  = 1'b0;
            if (post_cnt_q == '0) begin
              state_d = S_DONE;
            end
          end
        end else if (post_cnt_q == '0) begin
          state_d = S_DONE;
        end else if (sample_en) begin
          we_c       = 1'b1;
          waddr_d    = waddr_q + ADDR_W'(1);
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_cnt_q == ADDR_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (clr_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      tp_q        <= '0;
      pend_q      <= 1'b0;
      triggered_q <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      tp_q        <= tp_d;
      pend_q      <= pend_d;
      triggered_q <= triggered_d;
      armed_q     <= (state_d == S_ARMED);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign armed        = armed_q;
  assign triggered    = triggered_q;
  assign we           = we_c;
  assign waddr        = waddr_q;
  assign trig_addr    = trig_addr_q;
  assign capture_done = done_q;

endmodule

// File: tb/tb_capture_seq.sv
// Scoreboard bench for capture_seq: a capture-window model predicts every RAM write
// address into a queue that a negedge monitor drains, plus per-cycle status checks.
module tb_capture_seq;

  localparam int DEPTH = 16;
  localparam logic [4:0] ALL = 5'b11111;

  logic       clk;
  logic       rst;
  logic       start;
  logic       clr_done;
  logic [3:0] trig_pos;
  logic       sample_en;
  logic [4:0] CH_Trig;
  logic       armed;
  logic       triggered;
  logic       we;
  logic [3:0] waddr;
  logic [3:0] trig_addr;
  logic       capture_done;

  capture_seq #(.ADDR_W(4), .NUM_CH(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .clr_done(clr_done),
    .trig_pos(trig_pos),
    .sample_en(sample_en),
    .CH_Trig(CH_Trig),
    .armed(armed),
    .triggered(triggered),
    .we(we),
    .waddr(waddr),
    .trig_addr(trig_addr),
    .capture_done(capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int cycIdx     = 0;
  int expQ[$];

  // Capture model: 0 idle, 1 filling, 2 waiting for trigger, 3 owing window samples, 4 done
  int mMode, mNext, mFilled, mTp, mOwed, mTrigAddr;
  bit mTrig;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else
      passCount++;
  endtask

  task automatic resetModel();
    mMode = 0; mNext = 0; mFilled = 0; mTp = 0; mOwed = 0; mTrigAddr = 0; mTrig = 0;
  endtask

  task automatic checkOutput();
    checkVal("armed", 32'(armed), 32'(mMode == 2));
    checkVal("triggered", 32'(triggered), 32'(mTrig));
    checkVal("capture_done", 32'(capture_done), 32'(mMode == 4));
    checkVal("waddr", 32'(waddr), 32'(mNext));
    checkVal("trig_addr", 32'(trig_addr), 32'(mTrigAddr));
    checkVal("missing_writes", 32'(expQ.size()), 32'd0);
  endtask

  // One clock: drive inputs, predict writes, advance the model, then check after the edge.
  task automatic applyStimulus(input bit st, input bit clr, input bit se,
                               input logic [4:0] trg, input logic [3:0] tpIn, input bit rs);
    bit weExp;
    start = st; clr_done = clr; sample_en = se; CH_Trig = trg; trig_pos = tpIn; rst = rs;
    weExp = se && (mMode == 1 || mMode == 2 || (mMode == 3 && mOwed != 0));
    if (weExp) expQ.push_back(mNext);
    if (rs) begin
      resetModel();
    end else begin
      case (mMode)
        0: if (st) begin
          mMode = 1; mNext = 0; mFilled = 0; mTp = int'(tpIn); mTrig = 0;
        end
        1: begin
          if (mFilled >= DEPTH - 1 - mTp) mMode = 2;
          if (se) begin mFilled++; mNext = (mNext + 1) % DEPTH; end
        end
        2: begin
          if (&trg) begin
            mTrigAddr = mNext; mTrig = 1; mMode = 3;
            mOwed = mTp + (se ? 0 : 1);
          end
          if (se) mNext = (mNext + 1) % DEPTH;
        end
        3: begin
          if (mOwed == 0) mMode = 4;
          else if (se) begin
            mNext = (mNext + 1) % DEPTH;
            mOwed--;
            if (mOwed == 0) mMode = 4;
          end
        end
        4: if (clr) mMode = 0;
        default: mMode = 0;
      endcase
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic finishCapture(input int period, input int trigAt, input bit trigNoSe,
                               input bit fillTrig, input bit startSpam, input int maxCyc);
    bit se, want;
    logic [4:0] trg;
    for (int i = 0; i < maxCyc && mMode != 4; i++) begin
      se = (cycIdx % period) == 0;
      want = (mMode == 2) && (trigAt < 0 || mNext == trigAt) && !(trigNoSe && se);
      if (want) trg = ALL;
      else if (mMode == 1 && fillTrig) trg = ALL;
      else if (mMode == 3) trg = 5'($urandom);
      else trg = 5'($urandom_range(0, 30));
      applyStimulus(startSpam, 1'b0, se, trg, 4'($urandom), 1'b0);
      cycIdx++;
    end
    checkVal("capture_done_reached", 32'(capture_done), 32'd1);
  endtask

  task automatic runCapture(input logic [3:0] tp, input int period, input int trigAt,
                            input bit trigNoSe, input bit fillTrig, input bit startSpam);
    cycIdx = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, ALL, tp, 1'b0);
    cycIdx = 1;
    finishCapture(period, trigAt, trigNoSe, fillTrig, startSpam, 400);
  endtask

  task automatic ackDone();
    applyStimulus(1'b0, 1'b1, 1'b1, ALL, 4'd0, 1'b0);
  endtask

  // Every strobed write must match the oldest predicted address.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_write: got write at %0d, expected no write (t=%0t)", waddr, $time);
      end else begin
        checkVal("write_addr", 32'(waddr), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    int period, trigAt;
    bit noSe;
    rst = 1'b1; start = 1'b0; clr_done = 1'b0; sample_en = 1'b0; CH_Trig = '0; trig_pos = '0;
    resetModel();

    for (int i = 0; i < 2; i++)
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 4'($urandom), 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, ALL, 4'd0, 1'b0);

    runCapture(4'd4, 1, 13, 1'b0, 1'b0, 1'b0);
    checkVal("nominal_trig_addr", 32'(trig_addr), 32'd13);
    checkVal("nominal_final_waddr", 32'(waddr), 32'd2);
    ackDone();

    runCapture(4'd4, 1, -1, 1'b0, 1'b1, 1'b0);
    checkVal("first_armed_trig_addr", 32'(trig_addr), 32'd12);
    ackDone();

    cycIdx = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, ALL, 4'd7, 1'b0);
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 5'b11011, 4'd0, 1'b0);
    checkVal("partial_trig_stays_armed", 32'(armed), 32'd1);
    finishCapture(1, -1, 1'b0, 1'b0, 1'b0, 100);
    ackDone();

    runCapture(4'd0, 1, -1, 1'b0, 1'b0, 1'b0);
    checkVal("tp0_trig_addr", 32'(trig_addr), 32'd0);
    checkVal("tp0_final_waddr", 32'(waddr), 32'd1);
    ackDone();

    runCapture(4'd15, 2, -1, 1'b0, 1'b0, 1'b0);
    checkVal("tp15_trig_addr", 32'(trig_addr), 32'd0);
    checkVal("tp15_final_waddr", 32'(waddr), 32'd0);
    ackDone();

    runCapture(4'd3, 3, -1, 1'b1, 1'b0, 1'b0);
    ackDone();

    runCapture(4'd5, 1, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, ALL, 4'd2, 1'b0);
    checkVal("start_ignored_in_done", 32'(capture_done), 32'd1);
    ackDone();

    cycIdx = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, ALL, 4'd8, 1'b0);
    for (int i = 0; i < 60 && mMode != 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, (mMode == 2) ? ALL : 5'd0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, ALL, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, ALL, 4'd0, 1'b1);
    checkVal("rst_mid_post_waddr", 32'(waddr), 32'd0);
    checkVal("rst_mid_post_triggered", 32'(triggered), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, ALL, 4'd0, 1'b0);

    runCapture(4'd6, 2, -1, 1'b0, 1'b0, 1'b0);
    ackDone();

    for (int n = 0; n < 25; n++) begin
      period = $urandom_range(1, 3);
      trigAt = ($urandom % 2) ? -1 : int'($urandom_range(0, 15));
      noSe   = (period > 1) && ($urandom % 2 == 1);
      runCapture(4'($urandom), period, trigAt, noSe, 1'($urandom), 1'($urandom));
      applyStimulus(1'($urandom), 1'b1, 1'($urandom), 5'($urandom), 4'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'($urandom), 5'($urandom), 4'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
